// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Receiver FSM states. The PARITY encoding stays reserved even when the
    // parity stage is not built, so state values match across builds.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int fifo_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: consumer-side read port and status pulses of the UART
// receiver. master = receiver, slave = consumer.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    logic                                    i_Rd_En;
    logic                                    o_Rd_Valid;
    logic [UART_DATA_BITS-1:0]               o_Rd_Byte;
    logic [fifo_count_width(FIFO_DEPTH)-1:0] o_Fifo_Count;
    logic                                    o_Framing_Err;
    logic                                    o_Overflow;
    logic                                    o_Parity_Err;

    modport master (
        input  i_Rd_En,
        output o_Rd_Valid, o_Rd_Byte, o_Fifo_Count,
        output o_Framing_Err, o_Overflow, o_Parity_Err
    );

    modport slave (
        output i_Rd_En,
        input  o_Rd_Valid, o_Rd_Byte, o_Fifo_Count,
        input  o_Framing_Err, o_Overflow, o_Parity_Err
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO with first-word-fall-through output.
// Simultaneous push and pop are both honoured, also when full; a pop while
// empty is ignored. DEPTH must be a power of two so pointers wrap naturally.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                               i_Clock,
    input  logic                               i_Rst_L,
    input  logic                               i_Push,
    input  logic [UART_DATA_BITS-1:0]          i_Data,
    input  logic                               i_Pop,
    output logic [UART_DATA_BITS-1:0]          o_Data,
    output logic                               o_Empty,
    output logic                               o_Full,
    output logic [fifo_count_width(DEPTH)-1:0] o_Count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = fifo_count_width(DEPTH);

    logic [UART_DATA_BITS-1:0] r_Mem [DEPTH];
    logic [AW-1:0]             r_Wr_Ptr;
    logic [AW-1:0]             r_Rd_Ptr;
    logic [CW-1:0]             r_Count;
    logic                      w_Do_Push;
    logic                      w_Do_Pop;

    assign o_Empty   = (r_Count == '0);
    assign o_Full    = (r_Count == CW'(DEPTH));
    assign o_Count   = r_Count;
    assign w_Do_Pop  = i_Pop & ~o_Empty;
    // A full FIFO still accepts a push when the same cycle frees an entry.
    assign w_Do_Push = i_Push & (~o_Full | w_Do_Pop);
    // Head byte shown directly; forced to zero while empty so the output is
    // defined after reset even though the storage array is not.
    assign o_Data    = o_Empty ? '0 : r_Mem[r_Rd_Ptr];

    // Storage write.
    // NOTE: the data array has no reset; pointers and count alone define
    // which entries are meaningful, and an unreset array maps to plain RAM.
    always_ff @(posedge i_Clock) begin
        if (w_Do_Push) begin
            r_Mem[r_Wr_Ptr] <= i_Data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: clocked state is always assigned with <= so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
        end else begin
            if (w_Do_Push) r_Wr_Ptr <= r_Wr_Ptr + AW'(1);
            if (w_Do_Pop)  r_Rd_Ptr <= r_Rd_Ptr + AW'(1);
            case ({w_Do_Push, w_Do_Pop})
                2'b10:   r_Count <= r_Count + CW'(1);
                2'b01:   r_Count <= r_Count - CW'(1);
                default: r_Count <= r_Count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first) feeding a byte FIFO.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit after data
// bit 7 (11-bit frame); a parity mismatch drops the byte and pulses
// o_Parity_Err. Without the macro, o_Parity_Err is tied low.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           i_Clock,
    input  logic           i_Rst_L,
    input  logic           i_RX_Serial,
    uart_rx_fifo_if.master rd_if
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    logic                      r_Rx_Meta;
    logic                      r_Rx_Sync;
    rx_state_t                 r_State,   w_State_Next;
    logic [CNT_W-1:0]          r_Clk_Cnt, w_Clk_Cnt_Next;
    logic [IDX_W-1:0]          r_Bit_Idx, w_Bit_Idx_Next;
    logic [UART_DATA_BITS-1:0] r_Shift,   w_Shift_Next;
    logic                      r_Push_Req, w_Push_Next;
    logic                      r_Framing_Err, w_Framing_Next;
    logic                      w_Full;
    logic                      w_Empty;
`ifdef UART_RX_PARITY_EN
    logic                      r_Par_Bit, w_Par_Bit_Next;
    logic                      r_Parity_Err, w_Parity_Next;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Rx_Meta <= 1'b1;
            r_Rx_Sync <= 1'b1;
        end else begin
            r_Rx_Meta <= i_RX_Serial;
            r_Rx_Sync <= r_Rx_Meta;
        end
    end

    // Receiver state register and per-frame datapath registers.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State       <= IDLE;
            r_Clk_Cnt     <= '0;
            r_Bit_Idx     <= '0;
            r_Shift       <= '0;
            r_Push_Req    <= 1'b0;
            r_Framing_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_Par_Bit     <= 1'b0;
            r_Parity_Err  <= 1'b0;
`endif
        end else begin
            r_State       <= w_State_Next;
            r_Clk_Cnt     <= w_Clk_Cnt_Next;
            r_Bit_Idx     <= w_Bit_Idx_Next;
            r_Shift       <= w_Shift_Next;
            r_Push_Req    <= w_Push_Next;
            r_Framing_Err <= w_Framing_Next;
`ifdef UART_RX_PARITY_EN
            r_Par_Bit     <= w_Par_Bit_Next;
            r_Parity_Err  <= w_Parity_Next;
`endif
        end
    end

    // Next-state and sampling decisions: mid-bit sampling of start, data,
    // optional parity and stop bit.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_State_Next   = r_State;
        w_Clk_Cnt_Next = r_Clk_Cnt;
        w_Bit_Idx_Next = r_Bit_Idx;
        w_Shift_Next   = r_Shift;
        w_Push_Next    = 1'b0;
        w_Framing_Next = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_Par_Bit_Next = r_Par_Bit;
        w_Parity_Next  = 1'b0;
`endif
        case (r_State)
            IDLE: begin
                w_Clk_Cnt_Next = '0;
                w_Bit_Idx_Next = '0;
                if (!r_Rx_Sync) w_State_Next = START;
            end
            START: begin
                if (r_Clk_Cnt == CNT_HALF) begin
                    w_Clk_Cnt_Next = '0;
                    // Line back high by mid start bit: a glitch, not a frame.
                    w_State_Next   = r_Rx_Sync ? IDLE : DATA;
                end else begin
                    w_Clk_Cnt_Next = r_Clk_Cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (r_Clk_Cnt == CNT_LAST) begin
                    w_Clk_Cnt_Next          = '0;
                    w_Shift_Next[r_Bit_Idx] = r_Rx_Sync;
                    if (r_Bit_Idx == IDX_LAST) begin
                        w_Bit_Idx_Next = '0;
`ifdef UART_RX_PARITY_EN
                        w_State_Next   = PARITY;
`else
                        w_State_Next   = STOP;
`endif
                    end else begin
                        w_Bit_Idx_Next = r_Bit_Idx + IDX_W'(1);
                    end
                end else begin
                    w_Clk_Cnt_Next = r_Clk_Cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_Clk_Cnt == CNT_LAST) begin
                    w_Clk_Cnt_Next = '0;
                    w_Par_Bit_Next = r_Rx_Sync;
                    w_State_Next   = STOP;
                end else begin
                    w_Clk_Cnt_Next = r_Clk_Cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (r_Clk_Cnt == CNT_LAST) begin
                    w_Clk_Cnt_Next = '0;
                    if (r_Rx_Sync) begin
                        w_State_Next = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (r_Par_Bit == ^r_Shift) w_Push_Next   = 1'b1;
                        else                       w_Parity_Next = 1'b1;
`else
                        w_Push_Next  = 1'b1;
`endif
                    end else begin
                        // Framing error outranks parity and overflow.
                        w_Framing_Next = 1'b1;
                        w_State_Next   = WAIT_HIGH;
                    end
                end else begin
                    w_Clk_Cnt_Next = r_Clk_Cnt + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                // A held-low (break) line must not re-trigger start detection.
                if (r_Rx_Sync) w_State_Next = IDLE;
            end
            default: begin
                w_State_Next = IDLE;
            end
        endcase
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .i_Push  (r_Push_Req),
        .i_Data  (r_Shift),
        .i_Pop   (rd_if.i_Rd_En),
        .o_Data  (rd_if.o_Rd_Byte),
        .o_Empty (w_Empty),
        .o_Full  (w_Full),
        .o_Count (rd_if.o_Fifo_Count)
    );

    assign rd_if.o_Rd_Valid    = ~w_Empty;
    assign rd_if.o_Framing_Err = r_Framing_Err;
    // Overflow is decided in the push cycle itself, since a pop in that same
    // cycle makes room for the byte.
    assign rd_if.o_Overflow    = r_Push_Req & w_Full & ~rd_if.i_Rd_En;
`ifdef UART_RX_PARITY_EN
    assign rd_if.o_Parity_Err  = r_Parity_Err;
`else
    assign rd_if.o_Parity_Err  = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with a byte FIFO: deserialises 8N1 frames (LSB first) from the serial line and buffers the received bytes for a consumer that drains them at its own pace. It is the receive end of the link driven by the team's UART transmitter. It detects framing errors and FIFO overflow, and replaces the bare single-byte receive path wherever bytes can arrive faster than the consumer reads them.

## Interface
- CLKS_PER_BIT, 217, clocks per UART bit (25 MHz / 115200); must be ≥ 8
- FIFO_DEPTH, 4, FIFO entries; must be a power of two and ≥ 2
- i_Clock  in  1  system clock, all logic on rising edge
- i_Rst_L  in  1  asynchronous active-low reset
- i_RX_Serial  in  1  asynchronous serial line, idle high
- i_Rd_En  in  1  pop request; acts only when o_Rd_Valid=1
- o_Rd_Valid  out  1  FIFO not empty
- o_Rd_Byte  out  8  head-of-FIFO byte (first-word-fall-through)
- o_Fifo_Count  out  $clog2(FIFO_DEPTH+1)  bytes currently held
- o_Framing_Err  out  1  one-cycle pulse: stop bit sampled low
- o_Overflow  out  1  one-cycle pulse: good frame arrived with FIFO full, byte dropped
- o_Parity_Err  out  1  one-cycle pulse: parity mismatch (constant 0 unless UART_RX_PARITY_EN)

## Operation
- i_RX_Serial passes through a 2-flop synchroniser; both flops reset to 1.
- FSM states: IDLE, START, DATA, (PARITY), STOP, WAIT_HIGH.
- IDLE: when the synced line is 0, go to START and clear the bit counter.
- START: at count CLKS_PER_BIT/2 (integer division), sample the line. If 0, go to DATA and clear the count. If 1, treat it as a glitch and return to IDLE.
- DATA: at count CLKS_PER_BIT-1, sample into shift bit index 0..7 (LSB first) and clear the count. After index 7, go to PARITY if the parity feature is compiled in, otherwise STOP.
- STOP: at count CLKS_PER_BIT-1, sample the stop bit.
  - Stop bit 1 with no error: push the byte, or pulse o_Overflow if the FIFO is full and no pop occurs that cycle. Go to IDLE.
  - Stop bit 0: pulse o_Framing_Err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until the synced line is 1, then go to IDLE. This prevents a held-low line from being read as back-to-back starts.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (no overflow) and when it is empty with a push (the byte appears next cycle).
  - A pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_Fifo_Count is exact: +1 on push, −1 on pop, unchanged on both or neither.
- Error pulses are mutually exclusive per frame. Priority: framing > parity > overflow.

## Timing
- Reset values: o_Rd_Valid=0, o_Rd_Byte=0, o_Fifo_Count=0, all error pulses 0, FSM=IDLE, FIFO empty.
- Reset asserted mid-frame aborts the frame. No push or error pulse is produced for it.
- Start-edge-to-IDLE-detect latency is 2 cycles (synchroniser).
- Push and error pulses are registered. They occur in the cycle after the stop-bit sample. o_Rd_Valid rises in the following cycle.
- o_Rd_Byte is valid whenever o_Rd_Valid=1. It updates in the cycle after a pop.
- End of stop-bit sample to first possible start detect is ≤ CLKS_PER_BIT/2 cycles, so a transmitter sending back-to-back frames with one stop bit is received without loss.

## Configuration
- UART_RX_PARITY_EN defined:
  - An even-parity bit follows data bit 7, giving an 11-bit frame.
  - The PARITY state samples it at CLKS_PER_BIT-1.
  - On mismatch, o_Parity_Err pulses at push time and the byte is discarded (not pushed).
- UART_RX_PARITY_EN undefined:
  - No PARITY state and a 10-bit frame.
  - o_Parity_Err is tied to 0.

## Structure
- Package uart_pkg holds:
  - the FSM state enum (PARITY encoding always reserved)
  - localparam UART_DATA_BITS = 8
  - a function computing the count width from FIFO_DEPTH
- Sub-module uart_byte_fifo is a synchronous FIFO with FWFT output, push/pop/full/empty/count. The top level owns the synchroniser, FSM and error logic.

## Test plan
- Send 0x3F at CLKS_PER_BIT=217 → o_Rd_Valid=1, o_Rd_Byte=0x3F, o_Fifo_Count=1; pulse i_Rd_En → count 0, valid 0.
- Drive the line low for 50 cycles, then high → no push, no error pulse, FSM returns to IDLE.
- Send 0xA5 with stop bit 0, line held low for 3 bit times → exactly one o_Framing_Err pulse, count stays 0; the next valid 0x5A frame is received correctly.
- FIFO_DEPTH=4: send 0x01..0x05 back-to-back with no reads → count 4, one o_Overflow pulse on the 5th frame; reads return 0x01..0x04 in order.
- With the FIFO full, assert i_Rd_En in the exact push cycle of a new frame → no overflow, count stays 4, the new byte is last out.
- Drop i_Rst_L mid-DATA of 0x77 → all outputs reset; after release, 0xC3 is received correctly. With UART_RX_PARITY_EN, 0x01 sent with parity bit 0 → one o_Parity_Err pulse, no push.
